// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller for NUM_DIGITS digits.
// Double-buffered display data swaps only at the frame boundary, so a frame
// never mixes old and new digits. Adds leading-zero blanking, per-digit
// decimal point, PWM brightness within each digit slot and a frame-done strobe.
// Select and segment outputs are registered together so they switch on the
// same edge, which avoids ghosting the previous digit's segments.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS     = 6,
    parameter int SUB_DIV        = 3125,
    parameter int BRIGHT_W       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [4*NUM_DIGITS-1:0] Digit_Data,
    input  logic [NUM_DIGITS-1:0]   DP_In,
    input  logic                    Load,
    input  logic                    Blank_Lz,
    input  logic                    Enable,
    input  logic [BRIGHT_W-1:0]     Brightness,
    output logic [7:0]              Row_Scan_Sig,
    output logic [NUM_DIGITS-1:0]   Column_Scan_Sig,
    output logic                    Frame_Done
);

    localparam int SUB_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam int DIG_W = $clog2(NUM_DIGITS);

    localparam logic [SUB_W-1:0]      SUB_LAST  = SUB_W'(SUB_DIV - 1);
    localparam logic [BRIGHT_W-1:0]   STEP_LAST = {BRIGHT_W{1'b1}};
    localparam logic [DIG_W-1:0]      DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
    // "All off" level of each output bus; XOR with it converts active-high
    // segment/select patterns to the board polarity.
    localparam logic [7:0]            ROW_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] COL_OFF   = SEL_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                                 : {NUM_DIGITS{1'b0}};

    // Hex digit to active-high segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // Timing chain state
    logic [SUB_W-1:0]        sub_q,  sub_d;
    logic [BRIGHT_W-1:0]     step_q, step_d;
    logic [DIG_W-1:0]        dig_q,  dig_d;

    // Double buffer
    logic [4*NUM_DIGITS-1:0] disp_data_q;
    logic [NUM_DIGITS-1:0]   disp_dp_q;
    logic [4*NUM_DIGITS-1:0] pend_data_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q;
    logic                    pend_q;

    // Registered outputs
    logic [7:0]              row_q, row_d;
    logic [NUM_DIGITS-1:0]   col_q, col_d;
    logic                    frame_done_q;

    // Combinational helpers
    logic                    sub_end_s;
    logic                    step_end_s;
    logic                    frame_end_s;
    logic [NUM_DIGITS-1:0]   blank_s;
    logic [3:0]              cur_nib_s;
    logic [7:0]              seg_act_s;
    logic [NUM_DIGITS-1:0]   sel_act_s;
    logic                    lit_s;

    // Terminal-count detection and next-state of the scan counters.
    always_comb begin
        sub_end_s   = (sub_q == SUB_LAST);
        step_end_s  = sub_end_s && (step_q == STEP_LAST);
        frame_end_s = step_end_s && (dig_q == DIG_LAST);

        if (sub_end_s) begin
            sub_d  = {SUB_W{1'b0}};
            step_d = step_q + {{(BRIGHT_W-1){1'b0}}, 1'b1};
        end else begin
            sub_d  = sub_q + {{(SUB_W-1){1'b0}}, 1'b1};
            step_d = step_q;
        end

        if (!step_end_s) begin
            dig_d = dig_q;
        end else if (dig_q == DIG_LAST) begin
            dig_d = {DIG_W{1'b0}};
        end else begin
            dig_d = dig_q + {{(DIG_W-1){1'b0}}, 1'b1};
        end
    end

    // Leading-zero mask: walk down from the top digit while every nibble seen is zero.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        blank_s  = {NUM_DIGITS{1'b0}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (disp_data_q[4*i +: 4] == 4'h0);
            if (i > 0) begin
                blank_s[i] = zero_run & Blank_Lz;
            end else begin
                blank_s[i] = 1'b0;
            end
        end
    end

    // Active-high segment/select pattern for the current digit and PWM gating.
    always_comb begin
        cur_nib_s = disp_data_q[{dig_q, 2'b00} +: 4];
        seg_act_s = {disp_dp_q[dig_q], blank_s[dig_q] ? 7'h00 : seg_decode(cur_nib_s)};
        sel_act_s = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << dig_q;
        lit_s     = Enable && (step_q <= Brightness);
        if (lit_s) begin
            row_d = seg_act_s ^ ROW_OFF;
            col_d = sel_act_s ^ COL_OFF;
        end else begin
            row_d = ROW_OFF;
            col_d = COL_OFF;
        end
    end

    // Scan counters: sub-step, brightness step and digit index.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sub_q  <= {SUB_W{1'b0}};
            step_q <= {BRIGHT_W{1'b0}};
            dig_q  <= {DIG_W{1'b0}};
        end else begin
            sub_q  <= sub_d;
            step_q <= step_d;
            dig_q  <= dig_d;
        end
    end

    // Pending/display buffers: Load fills pending; boundary moves pending to display.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            disp_data_q <= {(4*NUM_DIGITS){1'b0}};
            disp_dp_q   <= {NUM_DIGITS{1'b0}};
            pend_data_q <= {(4*NUM_DIGITS){1'b0}};
            pend_dp_q   <= {NUM_DIGITS{1'b0}};
            pend_q      <= 1'b0;
        end else begin
            if (frame_end_s && pend_q) begin
                disp_data_q <= pend_data_q;
                disp_dp_q   <= pend_dp_q;
            end
            // A Load on the boundary cycle refills pending after the old
            // contents have been transferred, so it shows one frame later.
            if (Load) begin
                pend_data_q <= Digit_Data;
                pend_dp_q   <= DP_In;
                pend_q      <= 1'b1;
            end else if (frame_end_s) begin
                pend_q      <= 1'b0;
            end
        end
    end

    // Output registers: select, segments and frame strobe update on the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            row_q        <= ROW_OFF;
            col_q        <= COL_OFF;
            frame_done_q <= 1'b0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            frame_done_q <= frame_end_s;
        end
    end

    assign Row_Scan_Sig    = row_q;
    assign Column_Scan_Sig = col_q;
    assign Frame_Done      = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: 4 digits, 8-clock slot, 32-clock frame.
// The driver pushes the expected outputs of each clock edge into a queue,
// computed from a frame-position model; a monitor pops and compares.
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int SLOT  = 8;
    localparam int FRAME = ND * SLOT;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] Digit_Data;
    logic [3:0]  DP_In;
    logic        Load;
    logic        Blank_Lz;
    logic        Enable;
    logic [1:0]  Brightness;
    logic [7:0]  Row_Scan_Sig;
    logic [3:0]  Column_Scan_Sig;
    logic        Frame_Done;

    seg_scan_ctrl #(
        .NUM_DIGITS(4), .SUB_DIV(2), .BRIGHT_W(2),
        .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
    ) dut (
        .CLK(CLK), .RST(RST), .Digit_Data(Digit_Data), .DP_In(DP_In),
        .Load(Load), .Blank_Lz(Blank_Lz), .Enable(Enable), .Brightness(Brightness),
        .Row_Scan_Sig(Row_Scan_Sig), .Column_Scan_Sig(Column_Scan_Sig),
        .Frame_Done(Frame_Done)
    );

    always #5 CLK = ~CLK;

    logic [6:0] dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_tests = 0;
    int n_fail  = 0;

    // Expected {Frame_Done, Column, Row} per clock edge
    logic [12:0] exp_q [$];

    // Reference state: edges since reset plus the two data buffers
    int          m_k;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_dp, m_pdp;
    logic        m_pflag;

    // Requested static inputs, applied by the driver at each falling edge
    logic        t_en, t_blz;
    logic [1:0]  t_br;

    function automatic logic [12:0] model_out(int k, logic [15:0] disp, logic [3:0] dp,
                                              logic en, logic [1:0] br, logic blz);
        int pos, dig, step;
        logic lit, blank;
        logic [3:0] nib, col;
        logic [7:0] seg;
        pos   = k % FRAME;
        dig   = pos / SLOT;
        step  = (pos % SLOT) / 2;
        lit   = en && (step <= int'(br));
        nib   = 4'((disp >> (4 * dig)) & 16'h000F);
        blank = blz && (dig > 0) && ((disp >> (4 * dig)) == 16'h0000);
        seg   = {dp[dig], blank ? 7'h00 : dec[nib]};
        col   = ~(4'b0001 << dig);
        return {pos == FRAME - 1, lit ? col : 4'hF, lit ? ~seg : 8'hFF};
    endfunction

    task automatic model_reset();
        m_k = 0; m_disp = 16'h0; m_pend = 16'h0; m_dp = 4'h0; m_pdp = 4'h0; m_pflag = 1'b0;
    endtask

    // One clock: drive inputs at the falling edge and predict the next rising edge.
    task automatic cyc(input logic ld, input logic [15:0] d, input logic [3:0] dp);
        @(negedge CLK);
        Load = ld; Digit_Data = d; DP_In = dp;
        Enable = t_en; Brightness = t_br; Blank_Lz = t_blz;
        exp_q.push_back(model_out(m_k, m_disp, m_dp, t_en, t_br, t_blz));
        if ((m_k % FRAME == FRAME - 1) && m_pflag) begin
            m_disp = m_pend; m_dp = m_pdp; m_pflag = 1'b0;
        end
        if (ld) begin
            m_pend = d; m_pdp = dp; m_pflag = 1'b1;
        end
        m_k++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic check_idle(input string name);
        n_tests++;
        if ({Frame_Done, Column_Scan_Sig, Row_Scan_Sig} !== {1'b0, 4'hF, 8'hFF}) begin
            n_fail++;
            $display("FAIL %s: got fd=%b col=%b row=%h, need fd=0 col=1111 row=ff",
                     name, Frame_Done, Column_Scan_Sig, Row_Scan_Sig);
        end
    endtask

    // Monitor: every rising edge with an outstanding prediction is compared.
    always @(posedge CLK) begin
        logic [12:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if ({Frame_Done, Column_Scan_Sig, Row_Scan_Sig} !== e) begin
                n_fail++;
                $display("FAIL scan t=%0t: got fd=%b col=%b row=%h, need fd=%b col=%b row=%h",
                         $time, Frame_Done, Column_Scan_Sig, Row_Scan_Sig, e[12], e[11:8], e[7:0]);
            end
        end
    end

    initial begin
        logic [15:0] mask;
        RST = 1'b0; Load = 1'b0; Digit_Data = 16'h0; DP_In = 4'h0;
        t_en = 1'b1; t_br = 2'd3; t_blz = 1'b1;
        Enable = 1'b1; Brightness = 2'd3; Blank_Lz = 1'b1;
        model_reset();
        #1 RST = 1'b1;
        #1 check_idle("reset_init");
        @(posedge CLK); #1 check_idle("reset_held");
        @(posedge CLK); #2 RST = 1'b0;
        model_reset();

        // Basic load of 1234; old contents (0) shown until the boundary
        cyc(1'b1, 16'h1234, 4'h0);
        idle(70);

        // Leading-zero blanking with a DP on a blanked digit, then blanking off
        cyc(1'b1, 16'h0050, 4'b1000);
        idle(70);
        t_blz = 1'b0; idle(40);
        t_blz = 1'b1;

        // Brightness and enable gating
        t_br = 2'd0; idle(32);
        t_br = 2'd1; idle(32);
        t_en = 1'b0; idle(32);
        t_en = 1'b1; t_br = 2'd3;

        // Two loads in one frame: only the last reaches the display
        while (m_k % FRAME != 10) idle(1);
        cyc(1'b1, 16'hAAAA, 4'h0);
        idle(7);
        cyc(1'b1, 16'hBBBB, 4'h0);
        idle(70);

        // Load on the boundary cycle shows one frame later
        while (m_k % FRAME != FRAME - 1) idle(1);
        cyc(1'b1, 16'h5678, 4'b0101);
        idle(100);

        // Randomised traffic
        for (int i = 0; i < 640; i++) begin
            if ($urandom_range(0, 15) == 0) t_br = 2'($urandom);
            if ($urandom_range(0, 31) == 0) t_en = ~t_en;
            if ($urandom_range(0, 31) == 0) t_blz = ~t_blz;
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       mask = 16'hFFFF;
                    1:       mask = 16'h0FFF;
                    2:       mask = 16'h00FF;
                    default: mask = 16'h000F;
                endcase
                cyc(1'b1, 16'($urandom) & mask, 4'($urandom));
            end else begin
                idle(1);
            end
        end

        // Asynchronous reset in the middle of a lit slot
        t_en = 1'b1; t_br = 2'd3; t_blz = 1'b1;
        while (m_k % FRAME != 12) idle(1);
        @(posedge CLK); #3 RST = 1'b1;
        #1 check_idle("reset_async");
        @(posedge CLK); #1 check_idle("reset_hold");
        @(posedge CLK); #2 RST = 1'b0;
        model_reset();
        idle(40);

        @(posedge CLK); #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d predictions left, need 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
